// File: rtl/dmem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores over a req/ready
// handshake, with lane steering, sign/zero extension, error flagging and wait states.
module dmem_ctrl #(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W+1:0] addr,
   input  logic [31:0]       din,
   output logic [31:0]       dout,
   output logic              ready,
   output logic              err,
   output logic              busy
);

   typedef enum logic {S_IDLE, S_WAIT} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       din_q, din_d;
   logic [31:0]       dout_q, dout_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;

   logic [31:0]       mem [2**ADDR_W];

   logic              done;
   logic              acc_err;
   logic [3:0]        be;
   logic [31:0]       wdata;
   logic [31:0]       rword;
   logic [31:0]       ldata;
   logic [7:0]        lbyte;
   logic [15:0]       lhalf;
   logic [ADDR_W-1:0] widx;

   assign widx = addr_q[ADDR_W+1:2];
   assign done = (state_q == S_WAIT) && (cnt_q == '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         dout_q  <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         dout_q  <= dout_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      din_d   = din_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = S_WAIT;
               cnt_d   = 4'(WAIT_CYCLES);
               we_d    = we;
               f3_d    = funct3;
               addr_d  = addr;
               din_d   = din;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
            else             state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lane decode and legality for the latched request.
   always_comb begin
      acc_err = 1'b0;
      be      = '0;
      wdata   = '0;
      ldata   = '0;
      rword   = mem[widx];
      lbyte   = rword[{addr_q[1:0], 3'b000} +: 8];
      lhalf   = addr_q[1] ? rword[31:16] : rword[15:0];
      case (f3_q)
         3'b000, 3'b100: begin
            be    = 4'b0001 << addr_q[1:0];
            wdata = {4{din_q[7:0]}};
            ldata = f3_q[2] ? {24'd0, lbyte} : {{24{lbyte[7]}}, lbyte};
         end
         3'b001, 3'b101: begin
            acc_err = addr_q[0];
            be      = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{din_q[15:0]}};
            ldata   = f3_q[2] ? {16'd0, lhalf} : {{16{lhalf[15]}}, lhalf};
         end
         3'b010: begin
            acc_err = (addr_q[1:0] != 2'b00);
            be      = 4'b1111;
            wdata   = din_q;
            ldata   = rword;
         end
         default: acc_err = 1'b1;
      endcase
   end

   always_comb begin
      ready_d = done;
      err_d   = done & acc_err;
      dout_d  = dout_q;
      if (done && !we_q && !acc_err) dout_d = ldata;
   end

   // rstn guard keeps a store from landing if reset coincides with completion.
   always_ff @(posedge clk) begin
      if (rstn && done && we_q && !acc_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign dout  = dout_q;
   assign ready = ready_q;
   assign err   = err_q;
   assign busy  = (state_q == S_WAIT);

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller that replaces the single-cycle word-only data RAM beside the CPU core. It accepts byte, halfword and word loads and stores through a req/ready handshake. It performs lane selection and sign/zero extension, flags misaligned or illegal accesses, and inserts a configurable number of wait states so the core can be moved to multi-cycle or pipelined memory timing.

## Interface

Parameters:
- ADDR_W, 7, word-address bits; memory depth is 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 0, extra cycles between accept and completion; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  reset, asynchronous and active-low.
- req  in  1  access request; sampled only when busy=0.
- we  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  access size: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; all others illegal.
- addr  in  ADDR_W+2  byte address; addr[1:0] selects lane.
- din  in  32  store data, right-aligned: byte in [7:0], half in [15:0].
- dout  out  32  load result, extended to 32 bits.
- ready  out  1  one-cycle completion pulse.
- err  out  1  valid with ready; access was misaligned or illegal.
- busy  out  1  access in flight; new req ignored.

## Operation

- States: IDLE, WAIT. At reset: IDLE, ready=0, err=0, busy=0, dout=0, wait counter=0. Memory array is not cleared.
- IDLE with req=1 at an edge: latch we, funct3, addr and din; set busy=1; load counter with WAIT_CYCLES; go to WAIT.
- WAIT: if counter≠0, decrement. If counter=0, complete the access at that edge: ready=1 for one cycle, busy=0, return to IDLE.
- Error check on the latched request:
  - Half access with addr[0]=1: error.
  - Word access with addr[1:0]≠00: error.
  - funct3 in {011, 110, 111}: error.
  - Errored access: completes with the normal latency, err=1, no memory write, dout unchanged.
- Store, word: write all four lanes.
- Store, half: write lanes {addr[1],1'b1}:{addr[1],1'b0} from din[15:0].
- Store, byte: write lane addr[1:0] from din[7:0].
- Other lanes are untouched. Write takes effect at the completing edge.
- Load: dout is registered at the completing edge.
  - Selected byte or half is placed at bit 0.
  - Signed funct3: sign-extend from bit 7 or bit 15.
  - Unsigned funct3: zero-extend.
- dout holds its value until the next successful load completes. Stores do not change dout.
- err is 0 whenever ready is 0.
- req arriving while busy=1 is ignored. It is not queued.
- Reset mid-access: the access is aborted, any pending store is discarded, and all outputs return to reset values.

## Timing

- Accept edge at t0. Completion edge at t0+1+WAIT_CYCLES. ready/err/dout are valid in the cycle after completion.
- busy is high from t0 to the completion edge. It is low in the ready cycle, so a req held in that cycle is accepted at the next edge.
- Throughput: one access per WAIT_CYCLES+2 cycles with back-to-back req.
- A load issued right after a store to the same address returns the stored data (write-then-read ordering is guaranteed).
- All outputs come from registers; there is no combinational path from inputs to outputs.

## Test plan

- Reset/idle: rstn=0 mid-WAIT with a pending store of 0xDEADBEEF to 0x10. Required: ready/busy/err=0 at once; a later load of 0x10 does not return 0xDEADBEEF.
- Word and latency: WAIT_CYCLES=3. Store 0x12345678 at 0x20, then load word 0x20. Required: each ready arrives 4 edges after accept; dout=0x12345678; busy high for exactly 4 cycles.
- Byte/half lanes: store word 0x00000000 at 0x40, SB 0x80 at 0x43, SH 0xFFFE at 0x40. Required:
  - word load returns 0x8000FFFE;
  - LB 0x43 returns 0xFFFFFF80;
  - LBU 0x43 returns 0x00000080;
  - LH 0x40 returns 0xFFFFFFFE;
  - LHU 0x40 returns 0x0000FFFE.
- Errors: LW at 0x22, SH at 0x41, funct3=011 at 0x40. Required: each gives ready=1 with err=1; the word at 0x40 is unchanged; dout is unchanged.
- Busy ignore: with WAIT_CYCLES=2, pulse a second req one cycle after accept. Required: only one ready pulse, and the memory is unaffected by the second request.
- Back-to-back: with WAIT_CYCLES=0, req held high for 6 cycles. Required: 3 accesses complete with ready on alternate cycles.
